// File: rtl/adder_input_packer.sv
// adder_input_packer: serial-to-parallel front end for the fixed-point adder tree.
// Collects NUM_INPUTS signed words per group, emits one packed vector with a
// single-cycle out_valid, and delays out_end_flag by DRAIN_CYCLES after the
// layer's last word so the adder pipeline can drain.
// Optional feature macro: ADDER_PACK_PAD_EN (emit zero-padded partial groups).
module adder_input_packer #(
    parameter int DATA_WIDTH   = 12,
    parameter int NUM_INPUTS   = 32,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_last,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_numbers,
    output logic                             out_valid,
    output logic                             out_end_flag
);

    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int VEC_W = NUM_INPUTS * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(NUM_INPUTS - 1);
    localparam logic [7:0]       DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        END
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [7:0]         drain_cnt, drain_next;
    logic [VEC_W-1:0]   buffer, buffer_next;
    logic [VEC_W-1:0]   merged;
    logic [VEC_W-1:0]   numbers_next;
    logic               valid_next;
    logic               end_next;
    logic               ready_next;
    logic               accept;

    // State register and all registered outputs; reset clears any partial group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= COLLECT;
            cnt          <= '0;
            drain_cnt    <= '0;
            buffer       <= '0;
            out_numbers  <= '0;
            out_valid    <= 1'b0;
            out_end_flag <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            drain_cnt    <= drain_next;
            buffer       <= buffer_next;
            out_numbers  <= numbers_next;
            out_valid    <= valid_next;
            out_end_flag <= end_next;
            in_ready     <= ready_next;
        end
    end

    // Next-state, slot merge, emit decision and drain countdown.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        drain_next   = drain_cnt;
        buffer_next  = buffer;
        numbers_next = out_numbers;
        valid_next   = 1'b0;
        end_next     = 1'b0;
        accept       = in_valid && in_ready;

        // Buffer with the incoming word dropped into the current slot.
        merged = buffer;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            if (cnt == CNT_W'(k)) begin
                merged[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
        end

        case (state)
            COLLECT: begin
                if (accept) begin
                    if (cnt == LAST_SLOT) begin
                        // Full group (with or without in_last) always emits once.
                        numbers_next = merged;
                        valid_next   = 1'b1;
                        buffer_next  = '0;
                        cnt_next     = '0;
                    end else if (in_last) begin
`ifdef ADDER_PACK_PAD_EN
                        numbers_next = merged;
                        valid_next   = 1'b1;
`endif
                        buffer_next  = '0;
                        cnt_next     = '0;
                    end else begin
                        buffer_next  = merged;
                        cnt_next     = cnt + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_next = DRAIN;
                        drain_next = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = END;
                    end_next   = 1'b1;
                end else begin
                    drain_next = drain_cnt - 8'd1;
                end
            end
            END: begin
                state_next = COLLECT;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase

        ready_next = (state_next == COLLECT);
    end

endmodule

// File: tb/tb_adder_input_packer.sv
// Self-checking bench for adder_input_packer: directed scenarios plus a random
// phase, checked every cycle against a transaction-level model that tracks the
// collected words and the expected pulse/blocking cycles.
module tb_adder_input_packer;

    localparam int W = 12;
    localparam int N = 32;
    localparam int D = 8;
`ifdef ADDER_PACK_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           in_last = 1'b0;
    logic [N*W-1:0] out_numbers;
    logic           out_valid;
    logic           out_end_flag;

    always #5 clk = ~clk;

    adder_input_packer #(
        .DATA_WIDTH  (W),
        .NUM_INPUTS  (N),
        .DRAIN_CYCLES(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_numbers (out_numbers),
        .out_valid   (out_valid),
        .out_end_flag(out_end_flag)
    );

    int ncmp  = 0;
    int nfail = 0;

    // Model state: cycle index, pending/held group, expected event cycles.
    int             cyc = 0;
    int             valid_cyc = -1;
    int             end_cyc = -1;
    int             blk_lo = 1;
    int             blk_hi = 0;
    logic [N*W-1:0] pend = '0;
    logic [N*W-1:0] held = '0;
    logic [W-1:0]   grp[$];

    function automatic logic exp_ready_at(input int c);
        return !(c >= blk_lo && c <= blk_hi);
    endfunction

    task automatic check_outputs();
        logic er, ev, ee;
        if (cyc == valid_cyc) held = pend;
        er = exp_ready_at(cyc);
        ev = (cyc == valid_cyc);
        ee = (cyc == end_cyc);
        ncmp++;
        assert (in_ready === er) else begin
            nfail++;
            $error("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, er);
        end
        ncmp++;
        assert (out_valid === ev) else begin
            nfail++;
            $error("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev);
        end
        ncmp++;
        assert (out_end_flag === ee) else begin
            nfail++;
            $error("FAIL out_end_flag cyc=%0d got=%b exp=%b", cyc, out_end_flag, ee);
        end
        ncmp++;
        assert (out_numbers === held) else begin
            nfail++;
            $error("FAIL out_numbers cyc=%0d got=%h exp=%h", cyc, out_numbers, held);
        end
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic l);
        logic [N*W-1:0] vec;
        if (v && exp_ready_at(cyc)) begin
            grp.push_back(d);
            if (grp.size() == N || l) begin
                if (grp.size() == N || PAD) begin
                    vec = '0;
                    foreach (grp[i]) vec[i*W +: W] = grp[i];
                    pend      = vec;
                    valid_cyc = cyc + 1;
                end
                grp.delete();
            end
            if (l) begin
                blk_lo  = cyc + 1;
                blk_hi  = cyc + 1 + D;
                end_cyc = cyc + 1 + D;
            end
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic l);
        @(negedge clk);
        check_outputs();
        in_valid = v;
        in_data  = d;
        in_last  = l;
        model_edge(v, d, l);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        ncmp++;
        assert (out_numbers === '0 && out_valid === 1'b0 &&
                out_end_flag === 1'b0 && in_ready === 1'b1) else begin
            nfail++;
            $error("FAIL reset_%s got nums=%h v=%b e=%b r=%b exp nums=0 v=0 e=0 r=1",
                   tag, out_numbers, out_valid, out_end_flag, in_ready);
        end
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        repeat (hold) @(negedge clk);
        check_reset_vals("held");
        reset = 1'b0;
        grp.delete();
        held = '0;
        pend = '0;
        valid_cyc = -1;
        end_cyc   = -1;
        blk_lo    = 1;
        blk_hi    = 0;
    endtask

    // Keep feeding random words until one slot is left, then close the layer.
    task automatic finish_group();
        for (int i = 0; i < 200 && !(grp.size() == N - 1 && exp_ready_at(cyc)); i++)
            step(1'b1, W'($urandom), 1'b0);
        step(1'b1, W'($urandom), 1'b1);
    endtask

    initial begin
        // Power-on reset
        apply_reset(2);

        // Full group 1..32 with in_last on the final word
        for (int i = 1; i <= N; i++) step(1'b1, W'(i), (i == N));

        // Hold in_valid with 0x7FF through drain/end; first accepted word goes to slot 0
        for (int i = 0; i < 12; i++) step(1'b1, 12'h7FF, 1'b0);
        finish_group();
        idle(12);

        // Two back-to-back groups of random data
        for (int i = 1; i <= 2*N; i++) step(1'b1, W'($urandom), (i == 2*N));
        idle(12);

        // Partial group of five negative words
        for (int i = 1; i <= 5; i++) step(1'b1, 12'hFFD, (i == 5));
        idle(12);

        // in_last on the very first slot
        step(1'b1, W'($urandom), 1'b1);
        idle(12);

        // Reset after ten words, then a clean group of 0x001
        for (int i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b0);
        apply_reset(1);
        for (int i = 1; i <= N; i++) step(1'b1, 12'h001, (i == N));
        idle(12);

        // Reset in the middle of a drain
        for (int i = 1; i <= 3; i++) step(1'b1, W'($urandom), (i == 3));
        idle(4);
        apply_reset(1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 24) == 0));
            if (i == 400) apply_reset(1);
        end
        idle(D + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
